// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg: shared FSM states, UART MMIO offsets and status-bit positions.
package uart_tx_queue_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} tx_state_e;

    localparam logic [3:0] UART_STATUS_OFS = 4'h0;
    localparam logic [3:0] UART_RX_OFS     = 4'h4;
    localparam logic [3:0] UART_TX_OFS     = 4'h8;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_OVF   = 2;

endpackage

// File: rtl/uart_tx_queue_mem.sv
// uart_tx_queue_mem: DEPTH x W storage with one write port and an asynchronous read port.
module uart_tx_queue_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers CPU byte stores and feeds them to the UART transmitter
// over a valid/ready handshake, with a dead cycle after each accepted byte.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic             flush,
    input  logic             clr_overflow,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             overflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    tx_state_e        state, state_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [7:0]       rd_data;
    logic             full, push, load;
    logic [PTR_W:0]   count_d;

    assign full     = (count == FULL_CNT);
    assign wr_ready = !full;
    assign tx_valid = (state == SEND);
    assign empty    = (count == '0) && !tx_valid;

    uart_tx_queue_mem #(.DEPTH(DEPTH), .W(8)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // GAP loads the next byte exactly like IDLE; only SEND blocks a load
    always_comb begin
        push    = wr_valid && !full && !flush;
        load    = !flush && (state != SEND) && (count != '0);
        count_d = (push && !load) ? count + CNT_ONE :
                  (!push && load) ? count - CNT_ONE : count;
        state_d = flush           ? IDLE :
                  (state == SEND) ? (tx_ready ? GAP : SEND) :
                  load            ? SEND : IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (load) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    tx_data <= rd_data;
                end
                count <= count_d;
            end
            // a dropped store wins over a same-cycle clear
            overflow <= (wr_valid && full && !flush) ? 1'b1 :
                        clr_overflow ? 1'b0 : overflow;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed checks of reset, latency, overflow, flush and pointer wrap.
module tb_uart_tx_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [3:0] count;
    logic       empty;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int maxc = 0;
    logic [7:0] got[$];
    logic [7:0] sent[$];

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .count        (count),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // records a handshake that will complete on the coming edge, then advances
    task automatic step();
        if (tx_valid && tx_ready) got.push_back(tx_data);
        @(posedge clk);
        #1;
        if (int'(count) > maxc) maxc = int'(count);
    endtask

    initial begin
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_data", tx_data, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // single byte: latency, handshake, gap, idle
        tx_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        step();
        wr_valid = 1'b0;
        chk("lat_not_yet", tx_valid, 0);
        chk("lat_count1", count, 1);
        step();
        chk("lat_tx_valid", tx_valid, 1);
        chk("lat_tx_data", tx_data, 8'h41);
        chk("lat_count0", count, 0);
        chk("lat_not_empty", empty, 0);
        step();
        chk("gap_tx_valid", tx_valid, 0);
        step();
        chk("idle_empty", empty, 1);
        chk("idle_tx_valid", tx_valid, 0);
        chk("single_sent", got.size(), 1);

        // fill: one byte on tx_data plus DEPTH queued, the next store is dropped
        got.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            step();
            if (i == 8) begin
                chk("fill_count8", count, 8);
                chk("fill_wr_ready", wr_ready, 0);
                chk("fill_no_ovf_yet", overflow, 0);
            end
        end
        wr_valid = 1'b0;
        chk("fill_overflow", overflow, 1);
        chk("fill_count_held", count, 8);
        chk("fill_head_valid", tx_valid, 1);
        chk("fill_head_data", tx_data, 0);

        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("clr_overflow", overflow, 0);

        // full queue: push refused while a load pops, set beats clear
        tx_ready = 1'b1;
        step();
        chk("full_gap", tx_valid, 0);
        wr_valid     = 1'b1;
        wr_data      = 8'hAA;
        clr_overflow = 1'b1;
        step();
        wr_valid     = 1'b0;
        clr_overflow = 1'b0;
        chk("full_pop_count", count, 7);
        chk("full_set_wins", overflow, 1);
        chk("full_next_data", tx_data, 1);
        for (int c = 0; c < 100 && got.size() < 9; c++) step();
        repeat (4) step();
        chk("drain_size", got.size(), 9);
        for (int i = 0; i < 9 && i < got.size(); i++) chk($sformatf("drain_byte%0d", i), got[i], i);
        chk("drain_empty", empty, 1);

        // flush mid-SEND with a handshake and a store in the same cycle
        got.delete();
        tx_ready = 1'b0;
        foreach (sent[i]) sent.delete(i);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h11 * (i + 1));
            step();
        end
        wr_valid = 1'b0;
        chk("pre_flush_count", count, 2);
        chk("pre_flush_data", tx_data, 8'h11);
        flush    = 1'b1;
        tx_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("flush_tx_valid", tx_valid, 0);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_overflow_kept", overflow, 1);
        chk("flush_byte_sent", got.size(), 1);
        repeat (3) step();
        chk("flush_no_new", tx_valid, 0);
        chk("flush_still_empty", count, 0);
        chk("flush_sent_total", got.size(), 1);

        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;

        // wrap: 3*DEPTH bytes with a mostly-stalled UART
        got.delete();
        maxc = 0;
        begin
            int k = 0;
            for (int c = 0; c < 2000 && got.size() < 3 * DEPTH; c++) begin
                tx_ready = ($urandom_range(0, 3) == 0);
                wr_valid = (k < 3 * DEPTH) && wr_ready;
                wr_data  = 8'(k * 7 + 3);
                sent.push_back(wr_data);
                if (!wr_valid) sent.pop_back();
                if (wr_valid) k++;
                step();
            end
        end
        wr_valid = 1'b0;
        chk("wrap_size", got.size(), 3 * DEPTH);
        for (int i = 0; i < got.size() && i < sent.size(); i++) chk($sformatf("wrap_byte%0d", i), got[i], sent[i]);
        chk("wrap_max_reached", maxc, DEPTH);
        chk("wrap_no_overflow", overflow, 0);

        // async reset while a byte is being offered
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        chk("mid_tx_valid", tx_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_idle", tx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
